// File: rtl/uart_pkg.sv
// Shared definitions for the 16x oversampling UART receiver.
// Contents: receiver state encoding, oversampling constants, and a
// 3-input majority helper used by the bit voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int         OS_RATE    = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] BIT_END    = 4'(OS_RATE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-side bus of the UART receiver.
//   rx_data     : received word
//   rx_valid    : rx_data holds an unconsumed word
//   rx_ready    : consumer accepts the word when rx_valid && rx_ready
//   busy        : receiver is working on a frame
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch
//   overrun_err : one-cycle pulse, a word was lost to a full holding register
// master = the receiver, slave = the consumer.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, busy, frame_err, parity_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, busy, frame_err, parity_err, overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_tick16.sv
// Oversample tick generator: one tick every div_l clk cycles.
//   clk, areset : clock, synchronous active-high reset
//   divisor     : clk cycles per oversample tick (live value)
//   clear       : restart the count so ticks align to this cycle
//   latch       : capture divisor into div_l
//   tick        : one-cycle strobe when the count reaches div_l-1
module uart_tick16 (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] divisor,
  input  logic        clear,
  input  logic        latch,
  output logic        tick
);

  logic [31:0] cnt;
  logic [31:0] div_l;
  logic        wrap;

  // Divisors of 0 or 1 both degenerate to a tick on every clk.
  always_comb begin
    wrap = (div_l <= 32'd1) || (cnt >= div_l - 32'd1);
  end

  assign tick = wrap;

  always_ff @(posedge clk) begin
    if (areset) begin
      cnt   <= '0;
      div_l <= '0;
    end else begin
      if (latch) begin
        div_l <= divisor;
      end
      if (clear || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampling with 3-sample majority voting.
// A falling edge on the synchronized line starts a frame; the start bit
// is re-checked at mid-bit so short glitches are rejected. Data arrives
// LSB first, an optional parity bit follows, and the stop bit is judged
// half a bit early so a back-to-back start edge is never missed.
//   clk, areset : clock, synchronous active-high reset
//   divisor     : clk cycles per oversample tick, latched per frame
//   rx          : asynchronous serial input, idle high
//   bus         : word handshake, busy flag and error pulses
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [31:0]           divisor,
  input  logic                  rx,
  uart_rx_os16_if.master        bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic                 rx_meta, rx_s;
  logic                 tick;
  logic [3:0]           os_cnt;
  logic [2:0]           bit_cnt;
  logic                 smp_lo, smp_mid;
  logic                 maj_bit;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q, parity_err_q, overrun_err_q;

  logic                 vote, at_hi, at_end, exp_par;
  logic                 start_det, commit, frame_set, parity_set;
  logic                 shift_en, par_chk;

  uart_tick16 u_tick (
    .clk     (clk),
    .areset  (areset),
    .divisor (divisor),
    .clear   (start_det),
    .latch   (start_det),
    .tick    (tick)
  );

  // Third sample is the live line value at os_cnt 9.
  always_comb begin
    vote    = maj3(smp_lo, smp_mid, rx_s);
    at_hi   = tick && (os_cnt == SAMPLE_HI);
    at_end  = tick && (os_cnt == BIT_END);
    exp_par = (^shreg) ^ (PARITY_ODD != 0);
  end

  always_comb begin
    state_n    = state;
    start_det  = 1'b0;
    commit     = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (at_hi && vote) begin
          state_n = IDLE;
        end else if (at_end) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (at_end) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (at_end) begin
          par_chk = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (at_hi) begin
          if (!vote) begin
            frame_set = 1'b1;
            state_n   = BREAK;
          end else if (par_bad) begin
            parity_set = 1'b1;
            state_n    = IDLE;
          end else begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage: sample capture and shift register (data path) ----
  always_ff @(posedge clk) begin
    if (tick && (os_cnt == SAMPLE_LO)) begin
      smp_lo <= rx_s;
    end
    if (tick && (os_cnt == SAMPLE_MID)) begin
      smp_mid <= rx_s;
    end
    if (at_hi) begin
      maj_bit <= vote;
    end
    if (shift_en) begin
      shreg <= {maj_bit, shreg[DATA_BITS-1:1]};
    end
  end

  // ---- stage: synchronizer, FSM state, counters, holding register ----
  always_ff @(posedge clk) begin
    if (areset) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      par_bad       <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_n;

      if (start_det) begin
        os_cnt <= '0;
      end else if (tick && (state != IDLE)) begin
        os_cnt <= os_cnt + 4'd1;
      end

      if (start_det) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (start_det) begin
        par_bad <= 1'b0;
      end else if (par_chk) begin
        par_bad <= (maj_bit != exp_par);
      end

      frame_err_q   <= frame_set;
      parity_err_q  <= parity_set;
      overrun_err_q <= 1'b0;

      // A consume in the commit cycle frees the register for the new word.
      if (commit) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= shreg;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_err_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.overrun_err = overrun_err_q;

endmodule
